fu_sweep_ctrl: RTL

Sequencer that exercises the shared 4-input function unit (fu4x16: 4-bit code in, 1-bit result out) in hardware. On a start pulse it walks all 16 input codes in ascending order and holds each code for a programmable settle time. It samples the unit's output into a 16-bit truth-table register and compares the result against a golden table latched at start. It sits between the lab control logic and the function unit, and replaces hand-written stimulus for on-board checking.

---
 rtl/fu_pkg.sv | 22 ++
 rtl/fu_settle_timer.sv | 33 +++
 rtl/fu_sweep_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fu_pkg.sv
// Shared types and constants for the function-unit sweep sequencer.
package fu_pkg;

    localparam int CODE_W     = 4;
    localparam int TABLE_W    = 16;
    localparam int SETTLE_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sweep_state_t;

    // Index of the lowest set bit; 0 when the vector is all zeros.
    function automatic logic [CODE_W-1:0] lowest_set(input logic [TABLE_W-1:0] v);
        lowest_set = '0;
        for (int i = TABLE_W - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = CODE_W'(i);
        end
    endfunction

endpackage

// File: rtl/fu_settle_timer.sv
// Per-code settle counter: counts 0..SETTLE and wraps, flagging the last count.
module fu_settle_timer
    import fu_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic [CODE_W-1:0] cnt,
    output logic              tc
);

    localparam logic [CODE_W-1:0] SETTLE_L = CODE_W'(SETTLE);

    logic [CODE_W-1:0] r_cnt;

    assign cnt = r_cnt;
    assign tc  = (r_cnt == SETTLE_L);

    // Clear dominates; when enabled the count wraps to zero at the terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tc ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fu_sweep_ctrl.sv
// Walks all 16 codes through the external function unit, captures its
// truth table and compares it against a golden table latched at start.
//
// state   | meaning
// IDLE    | waiting for start; results of an aborted sweep may remain in truth
// RUN     | driving fu_in, settling and sampling one code at a time
// DONE    | sweep finished; results held until the next accepted start
module fu_sweep_ctrl
    import fu_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [TABLE_W-1:0] expected,
    output logic [CODE_W-1:0]  fu_in,
    input  logic               fu_out,
    output logic               busy,
    output logic               done,
    output logic               valid,
    output logic [TABLE_W-1:0] truth,
    output logic               mismatch,
    output logic [CODE_W-1:0]  first_bad
);

    sweep_state_t        r_state;
    logic [CODE_W-1:0]   r_fu_in;
    logic [TABLE_W-1:0]  r_truth;
    logic [TABLE_W-1:0]  r_expected;
    logic                r_busy;
    logic                r_done;
    logic                r_valid;
    logic                r_mismatch;
    logic [CODE_W-1:0]   r_first_bad;

    logic                w_start_ok;
    logic                w_tmr_clr;
    logic                w_tmr_en;
    logic                w_tmr_tc;
    logic [CODE_W-1:0]   w_tmr_cnt;
    logic [TABLE_W-1:0]  w_truth_next;
    logic [TABLE_W-1:0]  w_diff;

    assign w_start_ok = start && !abort && (r_state != ST_RUN);
    assign w_tmr_en   = (r_state == ST_RUN);
    assign w_tmr_clr  = (r_state != ST_RUN) || abort;

    fu_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_tmr_clr),
        .en    (w_tmr_en),
        .cnt   (w_tmr_cnt),
        .tc    (w_tmr_tc)
    );

    // Table as it will look after this cycle's sample, so the final compare
    // sees the last bit without a one-cycle lag.
    always_comb begin
        w_truth_next          = r_truth;
        w_truth_next[r_fu_in] = fu_out;
        w_diff                = w_truth_next ^ r_expected;
    end

    // Sweep FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_fu_in     <= '0;
            r_truth     <= '0;
            r_expected  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            r_mismatch  <= 1'b0;
            r_first_bad <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_state     <= ST_RUN;
                        r_fu_in     <= '0;
                        r_truth     <= '0;
                        r_expected  <= expected;
                        r_busy      <= 1'b1;
                        r_valid     <= 1'b0;
                        r_mismatch  <= 1'b0;
                        r_first_bad <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_fu_in <= '0;
                        r_busy  <= 1'b0;
                    end else if (w_tmr_tc) begin
                        r_truth <= w_truth_next;
                        if (r_fu_in == CODE_W'(TABLE_W - 1)) begin
                            r_state     <= ST_DONE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_valid     <= 1'b1;
                            r_mismatch  <= |w_diff;
                            r_first_bad <= lowest_set(w_diff);
                        end else begin
                            r_fu_in <= r_fu_in + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fu_in     = r_fu_in;
    assign busy      = r_busy;
    assign done      = r_done;
    assign valid     = r_valid;
    assign truth     = r_truth;
    assign mismatch  = r_mismatch;
    assign first_bad = r_first_bad;

endmodule
